sevenseg_scan_ctrl: RTL and testbench

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

---
 rtl/sevenseg_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctrl
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display that
// shares one external BCD-to-7-segment decoder across all digits.
//
// Each digit gets a dwell of BLANK_CYC blanking cycles (all anodes off, kills
// ghosting while the anode switches) followed by SCAN_DIV SHOW cycles.
// A full scan therefore takes 4*(BLANK_CYC+SCAN_DIV) clk cycles.
//
// Parameters
//   SCAN_DIV   SHOW-phase length per digit in clk cycles (>= 2)
//   BLANK_CYC  blanking length between digits in clk cycles (>= 1)
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   digits    four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_mask   decimal-point enables, bit i = digit i, 1 = on
//   load      snapshot strobe; digits/dp_mask captured every cycle it is 1
//   dec_data  nibble presented to the external decoder (combinational)
//   dec_seg   decoder result, gfe_dcba, active-low, used in the same cycle
//   an        digit anode enables, active-low, at most one low
//   seg       registered segment drive, gfe_dcba, active-low
//   dp        registered decimal-point drive, active-low
//
// Build option
//   SEVENSEG_LZS_EN  when defined, leading zeros on digits 1..3 are blanked
//                    (a digit stays dark if it and every higher nibble is 0
//                    and its decimal point is off). Scan timing is unchanged.
// -----------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        load,
    output logic [3:0]  dec_data,
    input  logic [6:0]  dec_seg,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYC - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [BW-1:0] blank_cnt;
    logic [PW-1:0] pre;
    logic [15:0]   snap_d;
    logic [3:0]    snap_dp;

    // Values loaded into an/seg/dp on SHOW entry and on every SHOW cycle.
    logic [3:0] show_an;
    logic [6:0] show_seg;
    logic       show_dp;

    // Snapshot register: reset wins over load, so load during reset is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_d  <= 16'h0000;
            snap_dp <= 4'b0000;
        end else if (load) begin
            snap_d  <= digits;
            snap_dp <= dp_mask;
        end
    end

    // The shared decoder sees the nibble of the digit currently indexed.
    always_comb begin
        dec_data = snap_d[{idx, 2'b00} +: 4];
    end

`ifdef SEVENSEG_LZS_EN
    logic lz;

    // Digit idx is a leading zero when it and all higher nibbles are zero
    // and its decimal point is off. Digit 0 is never suppressed.
    always_comb begin
        lz = 1'b0;
        case (idx)
            2'd1:    lz = (snap_d[15:4]  == 12'h000) && !snap_dp[1];
            2'd2:    lz = (snap_d[15:8]  == 8'h00)   && !snap_dp[2];
            2'd3:    lz = (snap_d[15:12] == 4'h0)    && !snap_dp[3];
            default: lz = 1'b0;
        endcase
    end

    always_comb begin
        show_an  = ~(4'b0001 << idx);
        show_seg = dec_seg;
        show_dp  = ~snap_dp[idx];
        if (lz) begin
            show_an  = 4'b1111;
            show_seg = 7'h7F;
            show_dp  = 1'b1;
        end
    end
`else
    always_comb begin
        show_an  = ~(4'b0001 << idx);
        show_seg = dec_seg;
        show_dp  = ~snap_dp[idx];
    end
`endif

    // Scan FSM. Outputs are registered and move together with the state, so
    // the anode pattern always matches the phase: dark in BLANK, one digit
    // lit in SHOW. idx advances only on the SHOW->BLANK edge, which is also
    // the edge that turns every anode off, so two anodes are never low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BLANK;
            idx       <= 2'd0;
            blank_cnt <= '0;
            pre       <= '0;
            an        <= 4'b1111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (blank_cnt == BLANK_MAX) begin
                        state     <= SHOW;
                        blank_cnt <= '0;
                        pre       <= '0;
                        an        <= show_an;
                        seg       <= show_seg;
                        dp        <= show_dp;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                        an        <= 4'b1111;
                        seg       <= 7'h7F;
                        dp        <= 1'b1;
                    end
                end
                SHOW: begin
                    if (pre == PRE_MAX) begin
                        state <= BLANK;
                        pre   <= '0;
                        idx   <= idx + 2'd1;
                        an    <= 4'b1111;
                        seg   <= 7'h7F;
                        dp    <= 1'b1;
                    end else begin
                        pre <= pre + 1'b1;
                        an  <= show_an;
                        seg <= show_seg;
                        dp  <= show_dp;
                    end
                end
                default: begin
                    state <= BLANK;
                    an    <= 4'b1111;
                    seg   <= 7'h7F;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl
//
// Directed bench for sevenseg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2
// (6 cycles per digit, 24 per scan). A behavioural BCD decoder closes the
// dec_data -> dec_seg loop. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int DWELL     = SCAN_DIV + BLANK_CYC;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        load;
    logic [3:0]  dec_data;
    logic [6:0]  dec_seg;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests;
    int fails;

    // Scan-position model: phase within the dwell and the digit index of the
    // cycle about to be sampled, plus the snapshot the outputs reflect.
    int          m_ph;
    int          m_d;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    int          cnt_an[4];
    logic        mon_en;

    sevenseg_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .digits  (digits),
        .dp_mask (dp_mask),
        .load    (load),
        .dec_data(dec_data),
        .dec_seg (dec_seg),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external decoder (gfe_dcba, active-low) ----------------
    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb dec_seg = dec7(dec_data);

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    // Leading-zero suppression as seen from outside: digit i>=1 dark when it
    // and every higher nibble are zero and its point is off.
    function automatic logic suppressed(input logic [15:0] v, input logic [3:0] m, input int i);
        logic z;
        z = 1'b1;
        if (i == 0) return 1'b0;
        for (int j = i; j < 4; j++) if (nib(v, j) != 4'h0) z = 1'b0;
        return z && !m[i];
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // an must never show two low bits once reset has defined it.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            assert ($countones(~an) <= 1)
            else begin
                fails++;
                $error("FAIL an_onehot observed=%b expected=at most one low bit", an);
            end
        end
    end

    // Check n consecutive cycles against the scan model, then advance it.
    task automatic check_cycles(input int n);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_dd;
        logic       sup;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sup = 1'b0;
`ifdef SEVENSEG_LZS_EN
            sup = suppressed(m_digits, m_dp, m_d);
`endif
            if (m_ph < SCAN_DIV && !sup) begin
                e_an  = ~(4'b0001 << m_d);
                e_seg = dec7(nib(m_digits, m_d));
                e_dp  = ~m_dp[m_d];
            end else begin
                e_an  = 4'b1111;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            // idx moves to the next digit on the edge that starts blanking
            e_dd = (m_ph < SCAN_DIV) ? nib(m_digits, m_d) : nib(m_digits, (m_d + 1) % 4);
            chk("scan_an", {12'h0, an}, {12'h0, e_an});
            chk("scan_seg", {9'h0, seg}, {9'h0, e_seg});
            chk("scan_dp", {15'h0, dp}, {15'h0, e_dp});
            chk("scan_dec_data", {12'h0, dec_data}, {12'h0, e_dd});
            for (int b = 0; b < 4; b++) if (an[b] == 1'b0) cnt_an[b]++;
            m_ph++;
            if (m_ph == DWELL) begin
                m_ph = 0;
                m_d  = (m_d + 1) % 4;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests   = 0;
        fails   = 0;
        mon_en  = 1'b0;
        m_ph    = 0;
        m_d     = 0;
        for (int b = 0; b < 4; b++) cnt_an[b] = 0;

        // Reset with load held high: the snapshot must stay cleared.
        rst_n   = 1'b0;
        load    = 1'b1;
        digits  = 16'h1234;
        dp_mask = 4'b1111;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_load_ignored", {12'h0, dec_data}, 16'h0000);

        // Release reset and load 1234 on the first free edge (E0).
        rst_n   = 1'b1;
        dp_mask = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        chk("rel_blank_an", {12'h0, an}, 16'h000F);
        chk("rel_dec_data", {12'h0, dec_data}, 16'h0004);

        // One full scan of 1234 starting at digit 0 SHOW (E1..E24).
        m_digits = 16'h1234;
        m_dp     = 4'b0000;
        m_ph     = 0;
        m_d      = 0;
        check_cycles(24);
        check_cycles(1);  // E25: digit 0 shown again after 24 cycles

        // Load 0000 during digit 0 SHOW; seg still shows the old value next cycle.
        digits = 16'h0000;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load_seg_old", {9'h0, seg}, {9'h0, 7'b0011001});
        m_digits = 16'h0000;
        m_ph     = 2;
        m_d      = 0;
        check_cycles(23); // ends on digit 0 SHOW, first cycle

        // Mid-SHOW load of 0009: seg turns to "9" two cycles after load.
        chk("pre9_seg", {9'h0, seg}, {9'h0, 7'b1000000});
        digits = 16'h0009;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load9_seg_hold", {9'h0, seg}, {9'h0, 7'b1000000});
        @(negedge clk);
        chk("load9_seg_new", {9'h0, seg}, {9'h0, 7'b0010000});
        chk("load9_an_same", {12'h0, an}, 16'h000E);

        // Run into digit 2 SHOW, then a one-cycle reset.
        m_digits = 16'h0009;
        m_ph     = 3;
        m_d      = 0;
        check_cycles(11); // last sampled: digit 2, second SHOW cycle
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_an", {12'h0, an}, 16'h000F);
        chk("midrst_seg", {9'h0, seg}, 16'h007F);
        chk("midrst_dp", {15'h0, dp}, 16'h0001);
        chk("midrst_snap_clr", {12'h0, dec_data}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_blank", {12'h0, an}, 16'h000F);
        @(negedge clk);
        chk("postrst_dig0_an", {12'h0, an}, 16'h000E);
        chk("postrst_dig0_seg", {9'h0, seg}, {9'h0, 7'b1000000});

        // Nibble A on digit 1 with its decimal point on.
        digits  = 16'h00A5;
        dp_mask = 4'b0010;
        load    = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        m_digits = 16'h00A5;
        m_dp     = 4'b0010;
        m_ph     = 2;
        m_d      = 0;
        check_cycles(24);

        // 0070: digits 3 and 2 are leading zeros.
        digits  = 16'h0070;
        dp_mask = 4'b0000;
        load    = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        m_digits = 16'h0070;
        m_dp     = 4'b0000;
        m_ph     = 3;
        m_d      = 0;
        for (int b = 0; b < 4; b++) cnt_an[b] = 0;
        check_cycles(24);
        chk("lz_cnt_dig0", cnt_an[0][15:0], 16'd4);
        chk("lz_cnt_dig1", cnt_an[1][15:0], 16'd4);
`ifdef SEVENSEG_LZS_EN
        chk("lz_cnt_dig2", cnt_an[2][15:0], 16'd0);
        chk("lz_cnt_dig3", cnt_an[3][15:0], 16'd0);
`else
        chk("lz_cnt_dig2", cnt_an[2][15:0], 16'd4);
        chk("lz_cnt_dig3", cnt_an[3][15:0], 16'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
